ibwt_core: RTL and testbench

Streaming inverse Burrows-Wheeler transform engine, the parametrised successor to the forward `bwt_top`. It accepts one BWT-encoded block of `STRING_LEN` symbols of `CHAR_W` bits and reconstructs the original string by LF-mapping. The result is emitted in forward order with a valid/ready handshake. It sits directly downstream of `bwt_top` in the round-trip datapath and uses the same sentinel convention.

---
 rtl/ibwt_if.sv | 25 ++
 rtl/ibwt_core.sv | 129 ++++++++++++
 tb/tb_ibwt_core.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibwt_if.sv
// Streaming handshake bundle for the inverse BWT engine: BWT symbols in,
// reconstructed symbols out, plus status.
interface ibwt_if #(
  parameter int CHAR_W = 8
);
  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_ready;
  logic              out_valid;
  logic [CHAR_W-1:0] out_char;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              error;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char, out_last, busy, error
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char, out_last, busy, error
  );
endinterface

// File: rtl/ibwt_core.sv
// Inverse Burrows-Wheeler transform: loads one L column, builds C by prefix sum,
// walks the LF mapping back to front, then streams the string out in order.
//
// state   | meaning
// S_LOAD  | accept N symbols, record L, rank and occurrence counts
// S_COUNT | one code per cycle: occ -> exclusive prefix sum C, check sentinel
// S_WALK  | N cycles of LF mapping into the output buffer
// S_EMIT  | stream the output buffer with valid/ready
module ibwt_core #(
  parameter int          STRING_LEN = 64,
  parameter int          CHAR_W     = 8,
  parameter int unsigned SENTINEL   = 'h24
) (
  input logic   clk,
  input logic   rst,
  ibwt_if.slave bus
);
  localparam int IW = $clog2(STRING_LEN);
  localparam int OW = $clog2(STRING_LEN + 1);
  localparam int A  = 2 ** CHAR_W;
  localparam logic [CHAR_W-1:0] SENT  = CHAR_W'(SENTINEL);
  localparam logic [IW-1:0]     LAST  = IW'(STRING_LEN - 1);
  localparam logic [IW-1:0]     W_INI = IW'(STRING_LEN - 2);

  typedef enum logic [1:0] {S_LOAD, S_COUNT, S_WALK, S_EMIT} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]     i_q, j_q, p_q, w_q;
  logic [CHAR_W-1:0] k_q;
  logic [OW-1:0]     sum_q, sent_q;
  logic              error_q;

  logic [CHAR_W-1:0] l_q    [STRING_LEN];
  logic [IW-1:0]     rank_q [STRING_LEN];
  logic [CHAR_W-1:0] buf_q  [STRING_LEN];
  logic [OW-1:0]     occ_q  [A];

  logic              accept, count_done, walk_done, emit_hs, to_load;
  logic [OW-1:0]     base;
  logic [CHAR_W-1:0] cur;
  logic [IW-1:0]     p_next;

  always_comb begin
    state_d    = state_q;
    accept     = (state_q == S_LOAD) && bus.in_valid;
    count_done = (state_q == S_COUNT) && (k_q == '1);
    walk_done  = (state_q == S_WALK) && (j_q == LAST);
    emit_hs    = (state_q == S_EMIT) && bus.out_ready;
    // The sentinel sorts first, so the ascending pass starts from its count.
    base       = (k_q == '0) ? occ_q[SENT] : sum_q;
    cur        = l_q[p_q];
    p_next     = occ_q[cur][IW-1:0] + rank_q[p_q];
    unique case (state_q)
      S_LOAD:  if (accept && i_q == LAST) state_d = S_COUNT;
      S_COUNT: if (count_done) state_d = (sent_q == OW'(1)) ? S_WALK : S_LOAD;
      S_WALK:  if (walk_done) state_d = S_EMIT;
      S_EMIT:  if (emit_hs && j_q == LAST) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
    to_load = (state_q != S_LOAD) && (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      w_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      sent_q  <= '0;
      error_q <= 1'b0;
      for (int n = 0; n < A; n++) occ_q[n] <= '0;
    end else begin
      state_q <= state_d;
      error_q <= count_done && (sent_q != OW'(1));
      unique case (state_q)
        S_LOAD: begin
          if (accept) begin
            l_q[i_q]           <= bus.in_char;
            rank_q[i_q]        <= occ_q[bus.in_char][IW-1:0];
            occ_q[bus.in_char] <= occ_q[bus.in_char] + OW'(1);
            i_q                <= i_q + IW'(1);
          end
          k_q <= '0;
        end
        S_COUNT: begin
          k_q <= k_q + CHAR_W'(1);
          if (k_q == '0) sent_q <= occ_q[SENT];
          if (k_q == SENT) begin
            occ_q[k_q] <= '0;
            sum_q      <= base;
          end else begin
            occ_q[k_q] <= base;
            sum_q      <= base + occ_q[k_q];
          end
          p_q <= '0;
          w_q <= W_INI;
          j_q <= '0;
        end
        S_WALK: begin
          buf_q[w_q] <= cur;
          p_q        <= p_next;
          // Final write lands on N-1 (the sentinel) even when N is not a power of two.
          w_q        <= (w_q == '0) ? LAST : w_q - IW'(1);
          j_q        <= walk_done ? '0 : j_q + IW'(1);
        end
        S_EMIT: begin
          if (emit_hs) j_q <= j_q + IW'(1);
        end
        default: ;
      endcase
      if (to_load) begin
        for (int n = 0; n < A; n++) occ_q[n] <= '0;
        i_q <= '0;
        j_q <= '0;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_char  = (state_q == S_EMIT) ? buf_q[j_q] : '0;
  assign bus.out_last  = (state_q == S_EMIT) && (j_q == LAST);
  assign bus.busy      = (state_q != S_LOAD);
  assign bus.error     = error_q;
endmodule

// File: tb/tb_ibwt_core.sv
// Bench for ibwt_core: three block sizes sharing one stimulus path; a scoreboard
// queue holds expected output symbols and a negedge monitor checks them.
module tb_ibwt_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid_t = 1'b0;
  logic [7:0] in_char_t  = '0;
  logic       out_ready_t = 1'b1;
  int         sel = 0;

  ibwt_if #(.CHAR_W(8)) b7 ();
  ibwt_if #(.CHAR_W(8)) b4 ();
  ibwt_if #(.CHAR_W(8)) b64 ();

  ibwt_core #(.STRING_LEN(7),  .CHAR_W(8), .SENTINEL('h24)) u7  (.clk(clk), .rst(rst), .bus(b7));
  ibwt_core #(.STRING_LEN(4),  .CHAR_W(8), .SENTINEL('h24)) u4  (.clk(clk), .rst(rst), .bus(b4));
  ibwt_core #(.STRING_LEN(64), .CHAR_W(8), .SENTINEL('h24)) u64 (.clk(clk), .rst(rst), .bus(b64));

  assign b7.in_valid   = in_valid_t && (sel == 0);
  assign b4.in_valid   = in_valid_t && (sel == 1);
  assign b64.in_valid  = in_valid_t && (sel == 2);
  assign b7.in_char    = in_char_t;
  assign b4.in_char    = in_char_t;
  assign b64.in_char   = in_char_t;
  assign b7.out_ready  = out_ready_t;
  assign b4.out_ready  = out_ready_t;
  assign b64.out_ready = out_ready_t;

  logic       in_ready_m, out_valid_m, out_last_m, busy_m, error_m;
  logic [7:0] out_char_m;
  always_comb begin
    in_ready_m = b7.in_ready; out_valid_m = b7.out_valid; out_last_m = b7.out_last;
    busy_m = b7.busy; error_m = b7.error; out_char_m = b7.out_char;
    if (sel == 1) begin
      in_ready_m = b4.in_ready; out_valid_m = b4.out_valid; out_last_m = b4.out_last;
      busy_m = b4.busy; error_m = b4.error; out_char_m = b4.out_char;
    end else if (sel == 2) begin
      in_ready_m = b64.in_ready; out_valid_m = b64.out_valid; out_last_m = b64.out_last;
      busy_m = b64.busy; error_m = b64.error; out_char_m = b64.out_char;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  logic [8:0] exp_q[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Backpressure pattern 1,0,0,1 read from bit 0 upward.
  logic [3:0] bp_pat = 4'b1001;
  logic       bp_en = 1'b0;
  int         bp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready_t = bp_pat[bp_cnt];
      bp_cnt = (bp_cnt + 1) % 4;
    end else begin
      out_ready_t = 1'b1;
    end
  end

  logic       stall_pend = 1'b0;
  logic [7:0] held_char;
  logic       held_last;
  always @(negedge clk) begin
    if (out_valid_m) begin
      if (stall_pend) begin
        chk("stall_char", int'(out_char_m), int'(held_char));
        chk("stall_last", int'(out_last_m), int'(held_last));
      end
      if (out_ready_t) begin
        stall_pend = 1'b0;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_char", int'(out_char_m), int'(e[7:0]));
          chk("out_last", int'(out_last_m), int'(e[8]));
        end
      end else begin
        stall_pend = 1'b1;
        held_char  = out_char_m;
        held_last  = out_last_m;
      end
    end else begin
      if (stall_pend) chk("valid_dropped", 0, 1);
      stall_pend = 1'b0;
    end
  end

  function automatic int key(byte c);
    return (c == 8'h24) ? -1 : int'(c);
  endfunction

  function automatic bit rot_less(string s, int a, int b);
    int n = s.len();
    for (int k = 0; k < n; k++) begin
      int ca = key(s[(a + k) % n]);
      int cb = key(s[(b + k) % n]);
      if (ca != cb) return ca < cb;
    end
    return 1'b0;
  endfunction

  // Reference forward BWT by sorting rotations with '$' lowest.
  function automatic string fwd_bwt(string s);
    int n = s.len();
    int idx[$];
    string r = s;
    for (int i = 0; i < n; i++) idx.push_back(i);
    for (int a = 1; a < n; a++) begin
      int t = idx[a];
      int b = a;
      while (b > 0 && rot_less(s, t, idx[b-1])) begin
        idx[b] = idx[b-1];
        b--;
      end
      idx[b] = t;
    end
    for (int i = 0; i < n; i++) r[i] = s[(idx[i] + n - 1) % n];
    return r;
  endfunction

  task automatic push_exp(string s);
    for (int k = 0; k < s.len(); k++) begin
      logic [8:0] e;
      e[7:0] = s[k];
      e[8]   = (k == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(string s);
    for (int k = 0; k < s.len(); k++) begin
      int guard = 0;
      while (!in_ready_m && guard < 2000) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 2000) chk("in_ready_timeout", 0, 1);
      in_valid_t = 1'b1;
      in_char_t  = s[k];
      @(posedge clk); #1;
    end
    in_valid_t = 1'b0;
  endtask

  task automatic check_latency(string name, int exp);
    int cyc = 0;
    while (!out_valid_m && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    chk(name, cyc, exp);
  endtask

  task automatic drain(string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid_m) && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_idle(string name);
    chk({name, "_in_ready"}, int'(in_ready_m), 1);
    chk({name, "_out_valid"}, int'(out_valid_m), 0);
    chk({name, "_out_last"}, int'(out_last_m), 0);
    chk({name, "_out_char"}, int'(out_char_m), 0);
    chk({name, "_busy"}, int'(busy_m), 0);
    chk({name, "_error"}, int'(error_m), 0);
  endtask

  initial begin
    string s1, s2;
    int cyc, hs0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sel = 0;
    check_idle("reset");

    // banana with first-output latency
    push_exp("banana$");
    send("annb$aa");
    chk("ready_low_after_load", int'(in_ready_m), 0);
    chk("busy_after_load", int'(busy_m), 1);
    check_latency("latency_n7", 263);
    drain("drain_banana");

    // sentinel 0x24 must still sort below space 0x20
    sel = 1;
    push_exp("a b$");
    send("ba$ ");
    check_latency("latency_n4", 260);
    drain("drain_space");

    // 64-symbol round trips through a reference forward transform
    sel = 2;
    s1 = "";
    for (int r = 0; r < 15; r++) s1 = {s1, "sdup"};
    s1 = {s1, "sdu$"};
    s2 = s1;
    for (int i = 0; i < 63; i++) s2[i] = (i % 9 == 4) ? 8'h20 : 8'h61 + byte'((i * 7) % 13);
    push_exp(s1);
    send(fwd_bwt(s1));
    check_latency("latency_n64", 320);
    drain("drain_rt1");
    push_exp(s2);
    send(fwd_bwt(s2));
    drain("drain_rt2");

    // no sentinel: error pulse, no output, then a clean block
    sel = 0;
    send("aaaaaaa");
    cyc = 0;
    while (!error_m && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    chk("error_delay", cyc, 256);
    chk("error_busy", int'(busy_m), 0);
    chk("error_in_ready", int'(in_ready_m), 1);
    @(posedge clk); #1;
    chk("error_one_cycle", int'(error_m), 0);
    push_exp("banana$");
    send("annb$aa");
    drain("drain_after_error");

    // backpressure
    bp_en = 1'b1;
    hs0 = hs_cnt;
    push_exp("banana$");
    send("annb$aa");
    drain("drain_bp");
    chk("bp_handshakes", hs_cnt - hs0, 7);
    bp_en = 1'b0;
    @(posedge clk); #1;

    // reset while walking
    send("annb$aa");
    repeat (259) @(posedge clk);
    #1;
    chk("in_walk_busy", int'(busy_m), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("after_rst");
    repeat (300) @(posedge clk);
    #1;
    chk("no_output_after_rst", int'(out_valid_m), 0);
    push_exp("banana$");
    send("annb$aa");
    drain("drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
